// File: rtl/exemem_reg.sv
// ---------------------------------------------------------------------------
// exemem_reg -- dual-issue EXE->MEM pipeline register.
//
// Captures both ALU results, pass-through memory/writeback control, the
// mul/div result, HI/LO and CP0 write info and the inst1 exception code, and
// presents them registered to the memory stage.
//
// Per-cycle priority: flush -> bubble; exe+mem stall -> hold;
// exe stall only -> bubble; mem stall only -> hold; otherwise capture.
//
// Slot squash: when inst1 is valid and carries an exception, slot 2 is
// killed on capture (valid/wreg/whilo/memtype cleared) and
// mem_inst2_killed pulses for one cycle if slot 2 was valid.
//
// Ports:
//   clk, resetn             clock, async active-low reset
//   exe_stall, mem_stall    stage stalls
//   flush                   CP0 exception/eret flush
//   exe_*                   execute-stage results and control
//   mem_*                   registered copies for the memory stage
//   mem_inst2_killed        one-cycle pulse on slot-2 squash
//
// Optional feature (macro EXEMEM_TRACE_EN):
//   defined   : mem_pc1/mem_pc2 are registered, mem_commit_cnt counts
//               captured valid slots (wraps mod 2^32)
//   undefined : mem_pc1/mem_pc2 tied to 0, mem_commit_cnt absent
// ---------------------------------------------------------------------------

// Per-slot control gating: an invalid slot never writes anything; a
// squashed slot loses its architectural side effects but keeps mreg, which
// only steers the load mux.
module exemem_slot_gate (
    input  logic       valid,
    input  logic       squash,
    input  logic       mreg,
    input  logic       wreg,
    input  logic [1:0] whilo,
    input  logic [7:0] memtype,
    output logic       mreg_g,
    output logic       wreg_g,
    output logic [1:0] whilo_g,
    output logic [7:0] memtype_g
);
    logic live;

    assign live      = valid & ~squash;
    assign mreg_g    = mreg & valid;
    assign wreg_g    = wreg & live;
    assign whilo_g   = whilo & {2{live}};
    assign memtype_g = memtype & {8{live}};
endmodule

module exemem_reg #(
    parameter int            DW       = 32,
    parameter int            AW       = 5,
    parameter int            EW       = 5,
    parameter int            OPW      = 8,
    parameter logic [EW-1:0] EXC_NONE = 5'h10,
    parameter logic [EW-1:0] EXC_OV   = 5'h0c
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            exe_stall,
    input  logic            mem_stall,
    input  logic            flush,
    input  logic [1:0]      exe_valid,
    input  logic [OPW-1:0]  exe_aluop,
    input  logic [DW-1:0]   exe_result1,
    input  logic [DW-1:0]   exe_result2,
    input  logic [2*DW-1:0] exe_mulres,
    input  logic [7:0]      exe_memtype1,
    input  logic [7:0]      exe_memtype2,
    input  logic            exe_mreg1,
    input  logic            exe_mreg2,
    input  logic [1:0]      exe_whilo1,
    input  logic [1:0]      exe_whilo2,
    input  logic            exe_wreg1,
    input  logic            exe_wreg2,
    input  logic [AW-1:0]   exe_wa1,
    input  logic [AW-1:0]   exe_wa2,
    input  logic [DW-1:0]   exe_w2ram1,
    input  logic [DW-1:0]   exe_w2ram2,
    input  logic            exe_wc0,
    input  logic [AW-1:0]   exe_cp0addr,
    input  logic [DW-1:0]   exe_cp0wdata,
    input  logic [EW-1:0]   exe_exccode,
    input  logic [DW-1:0]   exe_pc1,
    input  logic [DW-1:0]   exe_pc2,
    output logic [1:0]      mem_valid,
    output logic [OPW-1:0]  mem_aluop,
    output logic [DW-1:0]   mem_result1,
    output logic [DW-1:0]   mem_result2,
    output logic [2*DW-1:0] mem_mulres,
    output logic [7:0]      mem_memtype1,
    output logic [7:0]      mem_memtype2,
    output logic            mem_mreg1,
    output logic            mem_mreg2,
    output logic [1:0]      mem_whilo1,
    output logic [1:0]      mem_whilo2,
    output logic            mem_wreg1,
    output logic            mem_wreg2,
    output logic [AW-1:0]   mem_wa1,
    output logic [AW-1:0]   mem_wa2,
    output logic [DW-1:0]   mem_w2ram1,
    output logic [DW-1:0]   mem_w2ram2,
    output logic            mem_wc0,
    output logic [AW-1:0]   mem_cp0addr,
    output logic [DW-1:0]   mem_cp0wdata,
    output logic [EW-1:0]   mem_exccode,
    output logic [DW-1:0]   mem_pc1,
    output logic [DW-1:0]   mem_pc2,
    output logic            mem_inst2_killed
`ifdef EXEMEM_TRACE_EN
    ,
    output logic [31:0]     mem_commit_cnt
`endif
);
    localparam int NSLOT = 2;

    typedef struct packed {
        logic [1:0]      valid;
        logic [OPW-1:0]  aluop;
        logic [DW-1:0]   result1;
        logic [DW-1:0]   result2;
        logic [2*DW-1:0] mulres;
        logic [7:0]      memtype1;
        logic [7:0]      memtype2;
        logic            mreg1;
        logic            mreg2;
        logic [1:0]      whilo1;
        logic [1:0]      whilo2;
        logic            wreg1;
        logic            wreg2;
        logic [AW-1:0]   wa1;
        logic [AW-1:0]   wa2;
        logic [DW-1:0]   w2ram1;
        logic [DW-1:0]   w2ram2;
        logic            wc0;
        logic [AW-1:0]   cp0addr;
        logic [DW-1:0]   cp0wdata;
        logic [EW-1:0]   exccode;
    } stage_t;

    function automatic stage_t bubble();
        stage_t b;
        b         = '0;
        b.exccode = EXC_NONE;
        return b;
    endfunction

    // ---- control decode --------------------------------------------------
    logic load_bubble, capture;

    // exe_stall alone lets MEM drain, so a bubble goes in; mem_stall alone
    // holds (EXE is stalled upstream as well, nothing is lost).
    assign load_bubble = flush | (exe_stall & ~mem_stall);
    assign capture     = ~flush & ~exe_stall & ~mem_stall;

    logic has_exc, is_ov, squash;

    assign has_exc = (exe_exccode != EXC_NONE);
    assign is_ov   = (exe_exccode == EXC_OV);
    assign squash  = has_exc & exe_valid[0];

    // ---- per-slot gating -------------------------------------------------
    logic [NSLOT-1:0]       lane_squash, lane_mreg, lane_wreg;
    logic [NSLOT-1:0][1:0]  lane_whilo;
    logic [NSLOT-1:0][7:0]  lane_memtype;
    logic [NSLOT-1:0]       g_mreg, g_wreg;
    logic [NSLOT-1:0][1:0]  g_whilo;
    logic [NSLOT-1:0][7:0]  g_memtype;

    assign lane_squash  = {squash, 1'b0};   // only slot 2 can be squashed
    assign lane_mreg    = {exe_mreg2, exe_mreg1};
    assign lane_wreg    = {exe_wreg2, exe_wreg1};
    assign lane_whilo   = {exe_whilo2, exe_whilo1};
    assign lane_memtype = {exe_memtype2, exe_memtype1};

    for (genvar i = 0; i < NSLOT; i++) begin : g_slot
        exemem_slot_gate u_gate (
            .valid     (exe_valid[i]),
            .squash    (lane_squash[i]),
            .mreg      (lane_mreg[i]),
            .wreg      (lane_wreg[i]),
            .whilo     (lane_whilo[i]),
            .memtype   (lane_memtype[i]),
            .mreg_g    (g_mreg[i]),
            .wreg_g    (g_wreg[i]),
            .whilo_g   (g_whilo[i]),
            .memtype_g (g_memtype[i])
        );
    end

    // ---- capture value ---------------------------------------------------
    stage_t cap, st;

    always_comb begin
        cap          = '0;
        cap.valid    = {exe_valid[1] & ~squash, exe_valid[0]};
        cap.aluop    = exe_aluop;
        cap.result1  = exe_result1;
        cap.result2  = exe_result2;
        cap.mulres   = exe_mulres;
        cap.memtype1 = g_memtype[0];
        cap.memtype2 = g_memtype[1];
        cap.mreg1    = g_mreg[0];
        cap.mreg2    = g_mreg[1];
        // Overflow must not leave a partial HI/LO update behind.
        cap.whilo1   = is_ov ? 2'b00 : g_whilo[0];
        cap.whilo2   = g_whilo[1];
        cap.wreg1    = g_wreg[0];
        cap.wreg2    = g_wreg[1];
        cap.wa1      = exe_wa1;
        cap.wa2      = exe_wa2;
        cap.w2ram1   = exe_w2ram1;
        cap.w2ram2   = exe_w2ram2;
        cap.wc0      = exe_wc0 & ~has_exc;
        cap.cp0addr  = exe_cp0addr;
        cap.cp0wdata = exe_cp0wdata;
        cap.exccode  = exe_exccode;
    end

    // ---- pipeline register -----------------------------------------------
    logic killed;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            st     <= bubble();
            killed <= 1'b0;
        end else begin
            killed <= 1'b0;     // pulse: cleared on hold and bubble too
            if (load_bubble) begin
                st <= bubble();
            end else if (capture) begin
                st     <= cap;
                killed <= squash & exe_valid[1];
            end
        end
    end

    assign mem_valid        = st.valid;
    assign mem_aluop        = st.aluop;
    assign mem_result1      = st.result1;
    assign mem_result2      = st.result2;
    assign mem_mulres       = st.mulres;
    assign mem_memtype1     = st.memtype1;
    assign mem_memtype2     = st.memtype2;
    assign mem_mreg1        = st.mreg1;
    assign mem_mreg2        = st.mreg2;
    assign mem_whilo1       = st.whilo1;
    assign mem_whilo2       = st.whilo2;
    assign mem_wreg1        = st.wreg1;
    assign mem_wreg2        = st.wreg2;
    assign mem_wa1          = st.wa1;
    assign mem_wa2          = st.wa2;
    assign mem_w2ram1       = st.w2ram1;
    assign mem_w2ram2       = st.w2ram2;
    assign mem_wc0          = st.wc0;
    assign mem_cp0addr      = st.cp0addr;
    assign mem_cp0wdata     = st.cp0wdata;
    assign mem_exccode      = st.exccode;
    assign mem_inst2_killed = killed;

`ifdef EXEMEM_TRACE_EN
    // ---- trace: PCs and committed-slot counter ---------------------------
    logic [DW-1:0] pc1_r, pc2_r;
    logic [31:0]   commit_cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc1_r      <= '0;
            pc2_r      <= '0;
            commit_cnt <= '0;
        end else if (load_bubble) begin
            pc1_r <= '0;
            pc2_r <= '0;
        end else if (capture) begin
            pc1_r      <= exe_pc1;
            pc2_r      <= exe_pc2;
            // counts the slots that survive into MEM (post-squash)
            commit_cnt <= commit_cnt + {31'b0, cap.valid[0]} + {31'b0, cap.valid[1]};
        end
    end

    assign mem_pc1        = pc1_r;
    assign mem_pc2        = pc2_r;
    assign mem_commit_cnt = commit_cnt;
`else
    logic unused_pc;

    assign unused_pc = ^{exe_pc1, exe_pc2};
    assign mem_pc1   = '0;
    assign mem_pc2   = '0;
`endif
endmodule
